udp_srio_tx_arbiter: RTL and testbench

// Packet-granular round-robin arbiter sharing one 32-bit UDP-to-SRIO egress path between NUM_SRC
// 32-bit UDP packet streams, each produced by a UDP forwarding/width-conversion stage.

---
 rtl/udp_srio_tx_arbiter_if.sv | 33 +++
 rtl/udp_srio_tx_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_udp_srio_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_srio_tx_arbiter_if.sv
// Bundle of the per-source UDP streams and the shared SRIO egress stream.
// The master modport is the traffic side (sources plus downstream sink);
// the slave modport is the arbiter's view of the same wires.
interface udp_srio_tx_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [32*NUM_SRC-1:0] s_tdata;
  logic [NUM_SRC-1:0]    s_tvalid;
  logic [NUM_SRC-1:0]    s_tfirst;
  logic [4*NUM_SRC-1:0]  s_tkeep;
  logic [NUM_SRC-1:0]    s_tlast;
  logic [16*NUM_SRC-1:0] s_length;
  logic [NUM_SRC-1:0]    s_tready;

  logic [31:0]           m_tdata;
  logic                  m_tvalid;
  logic                  m_tfirst;
  logic [3:0]            m_tkeep;
  logic                  m_tlast;
  logic [15:0]           m_length;
  logic [2:0]            m_src_id;
  logic                  m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tfirst, s_tkeep, s_tlast, s_length, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tfirst, m_tkeep, m_tlast, m_length, m_src_id
  );

  modport master (
    output s_tdata, s_tvalid, s_tfirst, s_tkeep, s_tlast, s_length, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tfirst, m_tkeep, m_tlast, m_length, m_src_id
  );
endinterface

// File: rtl/udp_srio_tx_arbiter.sv
// Packet-granular round-robin arbiter: NUM_SRC 32-bit UDP streams share one
// SRIO egress path. The grant is locked for a whole packet, the winner's
// length and source index travel with the data, and a stall watchdog closes
// out a packet whose source stops mid-packet.
module udp_srio_tx_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  udp_srio_tx_arbiter_if.slave  bus,
  output logic [15:0]           pkt_count_o,
  output logic                  timeout_err_o,
  output logic                  drop_beat_o
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [2:0]       src_id_q, src_id_d;
  logic [15:0]      length_q, length_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_err_q, timeout_err_d;
  logic             drop_beat_q, drop_beat_d;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] orphan;
  logic [IDX_W-1:0]   win;
  logic               win_vld;
  logic [15:0]        win_len;

  logic [31:0] g_data;
  logic [3:0]  g_keep;
  logic        g_valid, g_first, g_last;

  // A new packet is a valid first beat; a valid non-first beat seen while idle
  // has no owner (e.g. the tail of an aborted packet) and is swallowed.
  assign req    = bus.s_tvalid & bus.s_tfirst;
  assign orphan = bus.s_tvalid & ~bus.s_tfirst & {NUM_SRC{~reset}};

  assign bus.m_length  = length_q;
  assign bus.m_src_id  = src_id_q;
  assign pkt_count_o   = pkt_count_q;
  assign timeout_err_o = timeout_err_q;
  assign drop_beat_o   = drop_beat_q;

  // Round-robin pick: first requester scanning upward from rr_q+1, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    win_len = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!win_vld && (i == idx) && req[i]) begin
          win_vld = 1'b1;
          win     = IDX_W'(i);
          win_len = bus.s_length[16*i +: 16];
        end
      end
    end
  end

  // Select the granted source's stream.
  always_comb begin
    g_data  = '0;
    g_keep  = '0;
    g_valid = 1'b0;
    g_first = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IDX_W'(i)) begin
        g_data  = bus.s_tdata[32*i +: 32];
        g_keep  = bus.s_tkeep[4*i +: 4];
        g_valid = bus.s_tvalid[i];
        g_first = bus.s_tfirst[i];
        g_last  = bus.s_tlast[i];
      end
    end
  end

  // Next-state and output decode for the IDLE/XFER/ABORT packet FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    src_id_d      = src_id_q;
    length_d      = length_q;
    pkt_count_d   = pkt_count_q;
    wd_d          = wd_q;
    timeout_err_d = 1'b0;
    drop_beat_d   = 1'b0;
    bus.s_tready  = '0;
    bus.m_tdata   = '0;
    bus.m_tvalid  = 1'b0;
    bus.m_tfirst  = 1'b0;
    bus.m_tkeep   = '0;
    bus.m_tlast   = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.s_tready = orphan;
        drop_beat_d  = |orphan;
        if (win_vld) begin
          grant_d  = win;
          src_id_d = 3'(win);
          length_d = win_len;
          wd_d     = '0;
          state_d  = XFER;
        end
      end

      XFER: begin
        bus.m_tdata  = g_data;
        bus.m_tkeep  = g_keep;
        bus.m_tvalid = g_valid;
        bus.m_tfirst = g_first;
        bus.m_tlast  = g_last;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_q == IDX_W'(i)) bus.s_tready[i] = bus.m_tready;
        end
        if (g_valid && bus.m_tready) begin
          wd_d = '0;
          if (g_last) begin
            state_d     = IDLE;
            rr_d        = grant_q;
            pkt_count_d = pkt_count_q + 16'd1;
          end
        end else if (!g_valid) begin
          // Only a silent source counts toward the watchdog; downstream
          // backpressure is never a stall of the source.
          if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            state_d       = ABORT;
            timeout_err_d = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end

      ABORT: begin
        // Closing beat with no valid bytes so the receiver can end the packet.
        bus.m_tvalid = 1'b1;
        bus.m_tlast  = 1'b1;
        if (bus.m_tready) begin
          state_d = IDLE;
          rr_d    = grant_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_q          <= IDX_W'(NUM_SRC - 1);
      src_id_q      <= '0;
      length_q      <= '0;
      pkt_count_q   <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
      drop_beat_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      src_id_q      <= src_id_d;
      length_q      <= length_d;
      pkt_count_q   <= pkt_count_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
      drop_beat_q   <= drop_beat_d;
    end
  end

endmodule

// File: tb/tb_udp_srio_tx_arbiter.sv
// Directed bench for udp_srio_tx_arbiter with two sources and a short watchdog.
`timescale 1ns/1ps
module tb_udp_srio_tx_arbiter;
  localparam int NS = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pkt_count;
  logic        timeout_err;
  logic        drop_beat;

  udp_srio_tx_arbiter_if #(.NUM_SRC(NS)) bus ();

  udp_srio_tx_arbiter #(.NUM_SRC(NS), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .pkt_count_o  (pkt_count),
    .timeout_err_o(timeout_err),
    .drop_beat_o  (drop_beat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        first;
    logic        last;
    logic [3:0]  keep;
    logic [2:0]  sid;
    logic [15:0] len;
    int          cyc;
  } beat_t;

  beat_t       log_q[$];
  bit          active[NS];
  int          beat[NS];
  int          nbeats[NS];
  int          pkt[NS];
  int          npkts[NS];
  int          stall_at[NS];
  logic [15:0] slen[NS];
  bit          sfire[NS];
  int          tr_mode;
  int          cyc_n;
  int          drop_cnt;
  int          to_cnt;
  int          n_chk;
  int          n_pass;

  function automatic logic [31:0] bdata(int s, int p, int b);
    return {8'hA0, 8'(s), 8'(p), 8'(b)};
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      bus.s_tvalid[i]          = active[i] && (beat[i] != stall_at[i]);
      bus.s_tfirst[i]          = (beat[i] == 0);
      bus.s_tlast[i]           = (beat[i] == nbeats[i] - 1);
      bus.s_tdata[32*i +: 32]  = bdata(i, pkt[i], beat[i]);
      bus.s_tkeep[4*i +: 4]    = 4'hF;
      bus.s_length[16*i +: 16] = slen[i];
    end
    case (tr_mode)
      1:       bus.m_tready = cyc_n[0];
      2:       bus.m_tready = 1'b0;
      default: bus.m_tready = 1'b1;
    endcase
  endtask

  task automatic sample();
    beat_t e;
    for (int i = 0; i < NS; i++) sfire[i] = bus.s_tvalid[i] & bus.s_tready[i];
    if (bus.m_tvalid && bus.m_tready) begin
      e.data  = bus.m_tdata;
      e.first = bus.m_tfirst;
      e.last  = bus.m_tlast;
      e.keep  = bus.m_tkeep;
      e.sid   = bus.m_src_id;
      e.len   = bus.m_length;
      e.cyc   = cyc_n;
      log_q.push_back(e);
    end
    if (drop_beat === 1'b1) drop_cnt++;
    if (timeout_err === 1'b1) to_cnt++;
  endtask

  task automatic advance();
    for (int i = 0; i < NS; i++) begin
      if (sfire[i]) begin
        beat[i]++;
        if (beat[i] == nbeats[i]) begin
          beat[i] = 0;
          pkt[i]++;
          if (pkt[i] == npkts[i]) active[i] = 1'b0;
        end
      end
    end
    cyc_n++;
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      drive();
      #1 sample();
      @(posedge clk);
      #1 advance();
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NS; i++) begin
      active[i] = 1'b0; beat[i] = 0; nbeats[i] = 0; pkt[i] = 0;
      npkts[i] = 0; stall_at[i] = -1; slen[i] = '0; sfire[i] = 1'b0;
    end
  endtask

  task automatic setup_src(int i, int nb, int np, logic [15:0] len, int start_beat, int stall);
    active[i] = 1'b1; beat[i] = start_beat; nbeats[i] = nb; pkt[i] = 0;
    npkts[i] = np; slen[i] = len; stall_at[i] = stall;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_srcs();
    cyc(2);
    reset = 1'b0;
    log_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_srcs();
    cyc(3);
    n_chk++; if (bus.m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b want 0", bus.m_tvalid); else n_pass++;
    n_chk++; if (bus.s_tready !== 2'b00) $display("FAIL reset_s_tready: got %b want 00", bus.s_tready); else n_pass++;
    n_chk++; if (bus.m_tdata !== 32'h0) $display("FAIL reset_m_tdata: got %h want 0", bus.m_tdata); else n_pass++;
    n_chk++; if (bus.m_tlast !== 1'b0) $display("FAIL reset_m_tlast: got %b want 0", bus.m_tlast); else n_pass++;
    n_chk++; if (bus.m_length !== 16'h0) $display("FAIL reset_m_length: got %h want 0", bus.m_length); else n_pass++;
    n_chk++; if (bus.m_src_id !== 3'h0) $display("FAIL reset_m_src_id: got %h want 0", bus.m_src_id); else n_pass++;
    n_chk++; if (pkt_count !== 16'h0) $display("FAIL reset_pkt_count: got %h want 0", pkt_count); else n_pass++;
    n_chk++; if ({timeout_err, drop_beat} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {timeout_err, drop_beat}); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [56:0] got, exp;
    log_q.delete();
    clear_srcs();
    setup_src(0, 4, 1, 16'd15, 0, -1);
    cyc(12);
    n_chk++; if (log_q.size() !== 4) $display("FAIL single_count: got %0d want 4", log_q.size()); else n_pass++;
    for (int b = 0; b < 4; b++) begin
      got = '0;
      if (b < log_q.size()) got = {log_q[b].data, log_q[b].first, log_q[b].last, log_q[b].keep, log_q[b].sid, log_q[b].len};
      exp = {bdata(0, 0, b), (b == 0), (b == 3), 4'hF, 3'd0, 16'd15};
      n_chk++; if (got !== exp) $display("FAIL single_beat%0d: got %h want %h", b, got, exp); else n_pass++;
    end
    n_chk++; if (pkt_count !== 16'd1) $display("FAIL single_pkt_count: got %0d want 1", pkt_count); else n_pass++;
    n_chk++; if (bus.m_length !== 16'd15) $display("FAIL single_len_hold: got %0d want 15", bus.m_length); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [56:0] got, exp;
    int          s, p, b, idx;
    do_reset();
    setup_src(0, 3, 2, 16'd11, 0, -1);
    setup_src(1, 3, 2, 16'd23, 0, -1);
    cyc(40);
    n_chk++; if (log_q.size() !== 12) $display("FAIL rr_count: got %0d want 12", log_q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      s = k % 2;
      p = k / 2;
      for (b = 0; b < 3; b++) begin
        idx = k * 3 + b;
        got = '0;
        if (idx < log_q.size()) got = {log_q[idx].data, log_q[idx].first, log_q[idx].last, log_q[idx].keep, log_q[idx].sid, log_q[idx].len};
        exp = {bdata(s, p, b), (b == 0), (b == 2), 4'hF, 3'(s), (s == 0) ? 16'd11 : 16'd23};
        n_chk++; if (got !== exp) $display("FAIL rr_pkt%0d_beat%0d: got %h want %h", k, b, got, exp); else n_pass++;
      end
      if (k > 0 && (k * 3) < log_q.size()) begin
        n_chk++;
        if (log_q[k*3].cyc - log_q[k*3-1].cyc < 2)
          $display("FAIL rr_bubble%0d: got gap %0d want >=2", k, log_q[k*3].cyc - log_q[k*3-1].cyc);
        else n_pass++;
      end
    end
    n_chk++; if (pkt_count !== 16'd4) $display("FAIL rr_pkt_count: got %0d want 4", pkt_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] got;
    log_q.delete();
    to_cnt = 0;
    clear_srcs();
    setup_src(0, 6, 1, 16'd23, 0, -1);
    tr_mode = 1;
    cyc(40);
    tr_mode = 0;
    n_chk++; if (log_q.size() !== 6) $display("FAIL bp_count: got %0d want 6", log_q.size()); else n_pass++;
    for (int b = 0; b < 6; b++) begin
      got = (b < log_q.size()) ? log_q[b].data : 32'h0;
      n_chk++; if (got !== bdata(0, 0, b)) $display("FAIL bp_beat%0d: got %h want %h", b, got, bdata(0, 0, b)); else n_pass++;
    end
    log_q.delete();
    clear_srcs();
    setup_src(0, 3, 1, 16'd11, 0, -1);
    tr_mode = 2;
    cyc(2000);
    n_chk++; if (log_q.size() !== 0) $display("FAIL bp_hold_count: got %0d want 0", log_q.size()); else n_pass++;
    n_chk++; if (bus.m_tvalid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", bus.m_tvalid); else n_pass++;
    tr_mode = 0;
    cyc(10);
    n_chk++; if (log_q.size() !== 3) $display("FAIL bp_resume_count: got %0d want 3", log_q.size()); else n_pass++;
    n_chk++; if (to_cnt !== 0) $display("FAIL bp_no_timeout: got %0d want 0", to_cnt); else n_pass++;
    n_chk++; if (pkt_count !== 16'd6) $display("FAIL bp_pkt_count: got %0d want 6", pkt_count); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [41:0] got, exp;
    log_q.delete();
    to_cnt = 0;
    drop_cnt = 0;
    clear_srcs();
    setup_src(1, 5, 1, 16'd19, 0, 2);
    cyc(30);
    n_chk++; if (log_q.size() !== 3) $display("FAIL to_count: got %0d want 3", log_q.size()); else n_pass++;
    got = '0;
    if (log_q.size() >= 3) got = {log_q[2].data, log_q[2].first, log_q[2].last, log_q[2].keep, log_q[2].sid, log_q[2].len[0]};
    exp = {32'h0, 1'b0, 1'b1, 4'h0, 3'd1, 1'b1};
    n_chk++; if (got !== exp) $display("FAIL to_abort_beat: got %h want %h", got, exp); else n_pass++;
    n_chk++;
    if (log_q.size() < 3 || (log_q[2].cyc - log_q[1].cyc) != 17)
      $display("FAIL to_latency: got %0d want 17", (log_q.size() >= 3) ? log_q[2].cyc - log_q[1].cyc : -1);
    else n_pass++;
    n_chk++; if (to_cnt !== 1) $display("FAIL to_err_pulses: got %0d want 1", to_cnt); else n_pass++;
    n_chk++; if (pkt_count !== 16'd6) $display("FAIL to_pkt_count: got %0d want 6", pkt_count); else n_pass++;
    stall_at[1] = -1;
    cyc(10);
    n_chk++; if (drop_cnt !== 3) $display("FAIL to_late_drops: got %0d want 3", drop_cnt); else n_pass++;
    n_chk++; if (active[1] !== 1'b0) $display("FAIL to_late_drained: got %b want 0", active[1]); else n_pass++;
    n_chk++; if (log_q.size() !== 3) $display("FAIL to_late_no_output: got %0d want 3", log_q.size()); else n_pass++;
    n_chk++; if (pkt_count !== 16'd6) $display("FAIL to_late_pkt_count: got %0d want 6", pkt_count); else n_pass++;
  endtask

  task automatic test_orphan();
    log_q.delete();
    drop_cnt = 0;
    clear_srcs();
    setup_src(0, 4, 1, 16'd15, 1, -1);
    cyc(8);
    n_chk++; if (drop_cnt !== 3) $display("FAIL orphan_drops: got %0d want 3", drop_cnt); else n_pass++;
    n_chk++; if (log_q.size() !== 0) $display("FAIL orphan_no_grant: got %0d want 0", log_q.size()); else n_pass++;
    n_chk++; if (bus.m_src_id !== 3'd1) $display("FAIL orphan_src_id_hold: got %0d want 1", bus.m_src_id); else n_pass++;
    n_chk++; if (bus.m_length !== 16'd19) $display("FAIL orphan_len_hold: got %0d want 19", bus.m_length); else n_pass++;
    drop_cnt = 0;
    clear_srcs();
    setup_src(0, 3, 1, 16'd7, 1, -1);
    setup_src(1, 3, 1, 16'd7, 1, -1);
    cyc(6);
    n_chk++; if (drop_cnt !== 2) $display("FAIL orphan_dual_drops: got %0d want 2", drop_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int waited;
    log_q.delete();
    clear_srcs();
    setup_src(0, 6, 1, 16'd23, 0, -1);
    waited = 0;
    while (log_q.size() < 2 && waited < 20) begin
      cyc(1);
      waited++;
    end
    n_chk++; if (log_q.size() < 2) $display("FAIL midrst_wait: got %0d beats want 2", log_q.size()); else n_pass++;
    reset = 1'b1;
    cyc(1);
    drive();
    #1;
    n_chk++; if (bus.m_tvalid !== 1'b0) $display("FAIL midrst_m_tvalid: got %b want 0", bus.m_tvalid); else n_pass++;
    n_chk++; if (bus.m_tlast !== 1'b0) $display("FAIL midrst_m_tlast: got %b want 0", bus.m_tlast); else n_pass++;
    n_chk++; if (bus.s_tready !== 2'b00) $display("FAIL midrst_s_tready: got %b want 00", bus.s_tready); else n_pass++;
    n_chk++; if ({bus.m_src_id, bus.m_length} !== 19'h0) $display("FAIL midrst_id_len: got %h want 0", {bus.m_src_id, bus.m_length}); else n_pass++;
    n_chk++; if (pkt_count !== 16'd0) $display("FAIL midrst_pkt_count: got %0d want 0", pkt_count); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_srcs();
    log_q.delete();
    setup_src(0, 1, 1, 16'd3, 0, -1);
    setup_src(1, 1, 1, 16'd3, 0, -1);
    cyc(10);
    n_chk++; if (log_q.size() !== 2) $display("FAIL midrst_tie_count: got %0d want 2", log_q.size()); else n_pass++;
    n_chk++;
    if (log_q.size() < 2 || log_q[0].sid !== 3'd0 || log_q[1].sid !== 3'd1)
      $display("FAIL midrst_tie_order: got %0d,%0d want 0,1",
               (log_q.size() > 0) ? int'(log_q[0].sid) : -1, (log_q.size() > 1) ? int'(log_q[1].sid) : -1);
    else n_pass++;
    n_chk++;
    if (log_q.size() < 1 || {log_q[0].first, log_q[0].last} !== 2'b11)
      $display("FAIL midrst_one_beat: got %b want 11", (log_q.size() > 0) ? {log_q[0].first, log_q[0].last} : 2'b00);
    else n_pass++;
  endtask

  initial begin
    reset    = 1'b1;
    tr_mode  = 0;
    cyc_n    = 0;
    drop_cnt = 0;
    to_cnt   = 0;
    n_chk    = 0;
    n_pass   = 0;
    clear_srcs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_orphan();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
